// File: rtl/piped_acc_dump.sv
// Integrate-and-dump accumulator for the piped_adder output stream.
// Sums dump_len qualified samples (or fewer on dump_req), presents the total
// with a one-cycle strobe and restarts the next period on the same edge so
// back-to-back samples are never lost. Optional saturation on overflow.
//
// Handshake: a sample is consumed on every rising edge where we=1 while the
// block is in RUN; there is no back-pressure. acc_valid is a single-cycle
// strobe that marks new acc_out/acc_cnt/ovf values, which then hold until the
// next dump.
module piped_acc_dump #(
  parameter int in_width  = 8,
  parameter int acc_width = 24,
  parameter int len_width = 16,
  parameter bit sat_en    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [in_width-1:0]  data_in,
  input  logic                 we,
  input  logic [len_width-1:0] dump_len,
  input  logic                 dump_req,
  output logic [acc_width-1:0] acc_out,
  output logic [len_width-1:0] acc_cnt,
  output logic                 acc_valid,
  output logic                 ovf,
  output logic                 state_dbg
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [len_width-1:0] LEN_ONE = {{(len_width-1){1'b0}}, 1'b1};
  localparam logic [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
  localparam logic [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

  logic [0:0]           state_q, state_d;
  logic [len_width-1:0] len_q, len_d;
  logic [acc_width-1:0] acc_q, acc_d;
  logic [len_width-1:0] cnt_q, cnt_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [acc_width-1:0] acc_out_q, acc_out_d;
  logic [len_width-1:0] acc_cnt_q, acc_cnt_d;
  logic                 acc_valid_q, acc_valid_d;
  logic                 ovf_q, ovf_d;

  logic [acc_width:0]   sum_wide;
  logic                 add_ovf;
  logic [acc_width-1:0] acc_sum;
  logic [acc_width-1:0] acc_next;
  logic [len_width-1:0] cnt_next;
  logic                 flag_next;
  logic                 dump_hit;
  logic [len_width-1:0] len_eff;

  // Per-cycle datapath: one guard bit catches overflow of the signed add.
  always_comb begin
    sum_wide  = {acc_q[acc_width-1], acc_q}
              + {{(acc_width+1-in_width){data_in[in_width-1]}}, data_in};
    add_ovf   = sum_wide[acc_width] ^ sum_wide[acc_width-1];
    acc_sum   = sum_wide[acc_width-1:0];
    if (sat_en && add_ovf) begin
      acc_sum = sum_wide[acc_width] ? ACC_MIN : ACC_MAX;
    end
    acc_next  = we ? acc_sum : acc_q;
    cnt_next  = cnt_q + {{(len_width-1){1'b0}}, we};
    flag_next = ovf_flag_q | (we & add_ovf);
    dump_hit  = dump_req | (we & (cnt_q == len_q - LEN_ONE));
    len_eff   = (dump_len == '0) ? LEN_ONE : dump_len;
  end

  // Next-state logic: IDLE/RUN control, accumulation and dump/restart.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_flag_d  = ovf_flag_q;
    acc_out_d   = acc_out_q;
    acc_cnt_d   = acc_cnt_q;
    acc_valid_d = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d    = ST_RUN;
          len_d      = len_eff;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_flag_d = 1'b0;
        end
      end
      default: begin
        if (!en) begin
          // Disable drops the partial sum; dumped outputs stay as they were.
          state_d    = ST_IDLE;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_flag_d = 1'b0;
        end else if (dump_hit) begin
          acc_out_d   = acc_next;
          acc_cnt_d   = cnt_next;
          ovf_d       = flag_next;
          acc_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_flag_d  = 1'b0;
          len_d       = len_eff;
        end else begin
          acc_d      = acc_next;
          cnt_d      = cnt_next;
          ovf_flag_d = flag_next;
        end
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_ONE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_flag_q  <= 1'b0;
      acc_out_q   <= '0;
      acc_cnt_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_flag_q  <= ovf_flag_d;
      acc_out_q   <= acc_out_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_valid_q <= acc_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign acc_cnt   = acc_cnt_q;
  assign acc_valid = acc_valid_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_piped_acc_dump.sv
// Bench for piped_acc_dump: three instances (24-bit wrap, 8-bit wrap,
// 8-bit saturate) share one stimulus stream and are compared every cycle
// against a sample-list reference model, plus directed sequences.
module tb_piped_acc_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  data_in;
  logic        we;
  logic [15:0] dump_len;
  logic        dump_req;

  logic [23:0] out0;
  logic [7:0]  out1, out2;
  logic [15:0] cnt0, cnt1, cnt2;
  logic        vld0, vld1, vld2;
  logic        ovf0, ovf1, ovf2;
  logic        st0, st1, st2;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  piped_acc_dump #(.in_width(8), .acc_width(24), .len_width(16), .sat_en(1'b0)) u_wide (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .we(we), .dump_len(dump_len),
    .dump_req(dump_req), .acc_out(out0), .acc_cnt(cnt0), .acc_valid(vld0), .ovf(ovf0),
    .state_dbg(st0));

  piped_acc_dump #(.in_width(8), .acc_width(8), .len_width(16), .sat_en(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .we(we), .dump_len(dump_len),
    .dump_req(dump_req), .acc_out(out1), .acc_cnt(cnt1), .acc_valid(vld1), .ovf(ovf1),
    .state_dbg(st1));

  piped_acc_dump #(.in_width(8), .acc_width(8), .len_width(16), .sat_en(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .we(we), .dump_len(dump_len),
    .dump_req(dump_req), .acc_out(out2), .acc_cnt(cnt2), .acc_valid(vld2), .ovf(ovf2),
    .state_dbg(st2));

  // Reference model: list of samples in the open period, folded at dump time.
  bit     m_run;
  int     m_len;
  int     m_q[$];
  bit     m_valid;
  longint m_out [3];
  longint m_cnt;
  bit     m_ovf [3];

  typedef struct {
    bit     en;
    bit     we;
    int     data;
    int     len;
    bit     req;
    bit     x_valid;
    longint x_out;
    longint x_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_len = 1;
    m_q.delete();
    m_valid = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      m_out[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Sum the period's samples in config k: 0 = 24-bit wrap, 1 = 8-bit wrap, 2 = 8-bit clamp.
  task automatic fold(input int k, output longint res, output bit of);
    int     w;
    longint mx, mn, r;
    w  = (k == 0) ? 24 : 8;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    r  = 0;
    of = 1'b0;
    foreach (m_q[i]) begin
      r += m_q[i];
      if (r > mx || r < mn) begin
        of = 1'b1;
        if (k == 2)      r = (r > mx) ? mx : mn;
        else if (r > mx) r -= (longint'(1) <<< w);
        else             r += (longint'(1) <<< w);
      end
    end
    res = r & ((longint'(1) <<< w) - 1);
  endtask

  task automatic model_cycle(input bit e, input bit w, input int d, input int l, input bit r);
    longint res;
    bit     of;
    m_valid = 1'b0;
    if (!m_run) begin
      if (e) begin
        m_run = 1'b1;
        m_len = (l == 0) ? 1 : l;
        m_q.delete();
      end
    end else if (!e) begin
      m_run = 1'b0;
      m_q.delete();
    end else begin
      if (w) m_q.push_back(int'($signed(d[7:0])));
      if (r || (w && m_q.size() == m_len)) begin
        m_valid = 1'b1;
        m_cnt = m_q.size();
        for (int k = 0; k < 3; k++) begin
          fold(k, res, of);
          m_out[k] = res;
          m_ovf[k] = of;
        end
        m_q.delete();
        m_len = (l == 0) ? 1 : l;
      end
    end
  endtask

  task automatic cmp_all();
    chk("state0", 64'(st0), 64'(m_run));
    chk("valid0", 64'(vld0), 64'(m_valid));
    chk("out0", 64'(out0), m_out[0]);
    chk("cnt0", 64'(cnt0), m_cnt);
    chk("ovf0", 64'(ovf0), 64'(m_ovf[0]));
    chk("valid1", 64'(vld1), 64'(m_valid));
    chk("out1", 64'(out1), m_out[1]);
    chk("cnt1", 64'(cnt1), m_cnt);
    chk("ovf1", 64'(ovf1), 64'(m_ovf[1]));
    chk("valid2", 64'(vld2), 64'(m_valid));
    chk("out2", 64'(out2), m_out[2]);
    chk("cnt2", 64'(cnt2), m_cnt);
    chk("ovf2", 64'(ovf2), 64'(m_ovf[2]));
  endtask

  // Driver: apply one cycle of inputs, advance model, clock, compare.
  task automatic step(input bit e, input bit w, input int d, input int l, input bit r);
    en       = e;
    we       = w;
    data_in  = d[7:0];
    dump_len = l[15:0];
    dump_req = r;
    model_cycle(e, w, d, l, r);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; data_in = '0; dump_len = '0; dump_req = 1'b0;
    model_reset();
    #12;
    chk("rst_out", 64'(out0), 0);
    chk("rst_cnt", 64'(cnt0), 0);
    chk("rst_valid", 64'(vld0), 0);
    chk("rst_ovf", 64'(ovf0), 0);
    chk("rst_state", 64'(st0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream 1..8, period 4.
    tbl.push_back('{1'b1, 1'b0, 0, 4, 1'b0, 1'b0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 1, 4, 1'b0, 1'b0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 2, 4, 1'b0, 1'b0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 3, 4, 1'b0, 1'b0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 4, 4, 1'b0, 1'b1, 10, 4});
    tbl.push_back('{1'b1, 1'b1, 5, 4, 1'b0, 1'b0, 10, 4});
    tbl.push_back('{1'b1, 1'b1, 6, 4, 1'b0, 1'b0, 10, 4});
    tbl.push_back('{1'b1, 1'b1, 7, 4, 1'b0, 1'b0, 10, 4});
    tbl.push_back('{1'b1, 1'b1, 8, 4, 1'b0, 1'b1, 26, 4});
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].we, tbl[i].data, tbl[i].len, tbl[i].req);
      chk("t1_valid", 64'(vld0), 64'(tbl[i].x_valid));
      chk("t1_out", 64'(out0), tbl[i].x_out);
      chk("t1_cnt", 64'(cnt0), tbl[i].x_cnt);
    end
    idle();

    // Gaps in we do not count toward the period.
    step(1'b1, 1'b0, 0, 3, 1'b0);
    step(1'b1, 1'b1, 5, 3, 1'b0);
    step(1'b1, 1'b0, 5, 3, 1'b0);
    step(1'b1, 1'b0, 5, 3, 1'b0);
    step(1'b1, 1'b1, 5, 3, 1'b0);
    chk("t2_novalid", 64'(vld0), 0);
    step(1'b1, 1'b1, 5, 3, 1'b0);
    chk("t2_valid", 64'(vld0), 1);
    chk("t2_out", 64'(out0), 15);
    idle();

    // Early dump including the same-cycle sample, then a fresh period.
    step(1'b1, 1'b0, 0, 100, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, -3, 100, 1'b0);
    step(1'b1, 1'b1, -3, 100, 1'b1);
    chk("t3_valid", 64'(vld0), 1);
    chk("t3_out", 64'(out0), 64'hFF_FFE8);
    chk("t3_cnt", 64'(cnt0), 8);
    step(1'b1, 1'b1, 2, 100, 1'b0);
    step(1'b1, 1'b0, 0, 100, 1'b1);
    chk("t3_next_out", 64'(out0), 2);
    chk("t3_next_cnt", 64'(cnt0), 1);
    step(1'b1, 1'b0, 0, 100, 1'b1);
    chk("t3_empty_out", 64'(out0), 0);
    chk("t3_empty_cnt", 64'(cnt0), 0);
    idle();

    // Overflow: wrap vs saturate on the 8-bit instances.
    step(1'b1, 1'b0, 0, 4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 100, 4, 1'b0);
    chk("t4_wrap_out", 64'(out1), 64'h90);
    chk("t4_wrap_ovf", 64'(ovf1), 1);
    chk("t4_sat_out", 64'(out2), 127);
    chk("t4_sat_ovf", 64'(ovf2), 1);
    chk("t4_wide_out", 64'(out0), 400);
    chk("t4_wide_ovf", 64'(ovf0), 0);
    idle();

    // dump_len=0 dumps every sample; mid-period length change deferred.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 7, 0, 1'b0);
    chk("t5_out_a", 64'(out0), 7);
    chk("t5_cnt_a", 64'(cnt0), 1);
    step(1'b1, 1'b1, -1, 0, 1'b0);
    chk("t5_out_b", 64'(out0), 64'hFF_FFFF);
    chk("t5_valid_b", 64'(vld0), 1);
    step(1'b1, 1'b1, 1, 4, 1'b0);
    step(1'b1, 1'b1, 1, 2, 1'b0);
    step(1'b1, 1'b1, 1, 2, 1'b0);
    chk("t5_no_early", 64'(vld0), 0);
    step(1'b1, 1'b1, 1, 2, 1'b0);
    step(1'b1, 1'b1, 1, 2, 1'b0);
    chk("t5_len4_valid", 64'(vld0), 1);
    chk("t5_len4_cnt", 64'(cnt0), 4);

    // Reset mid-period clears everything without a strobe.
    step(1'b1, 1'b1, 5, 4, 1'b0);
    step(1'b1, 1'b1, 5, 4, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 64'(out0), 0);
    chk("t6_rst_cnt", 64'(cnt0), 0);
    chk("t6_rst_valid", 64'(vld0), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 0, 4, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, i, 4, 1'b0);
    chk("t6_after_rst", 64'(out0), 10);
    // Drop en mid-period: partial discarded, outputs held.
    step(1'b1, 1'b1, 9, 4, 1'b0);
    step(1'b1, 1'b1, 9, 4, 1'b1 & 1'b0);
    step(1'b0, 1'b1, 9, 4, 1'b1);
    chk("t6_en_valid", 64'(vld0), 0);
    chk("t6_en_hold", 64'(out0), 10);
    step(1'b1, 1'b0, 0, 4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3, 4, 1'b0);
    chk("t6_after_en", 64'(out0), 12);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 6)),
           $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
